// File: rtl/reg_seq_defs.sv
// Shared op codes, state encodings and command bundle for the
// register-bus sequencer and its optional command buffer.
package reg_seq_defs;

   localparam int REG_IDX_W = 3;
   localparam int PC_INDEX  = 7;

   typedef enum logic [1:0] {
      OP_MOV     = 2'd0,
      OP_PCINC   = 2'd1,
      OP_PCRESET = 2'd2,
      OP_OUT     = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      LOAD  = 3'd2,
      INC   = 3'd3,
      PCRST = 3'd4
   } state_e;

   typedef struct packed {
      op_e                  op;
      logic [REG_IDX_W-1:0] src;
      logic [REG_IDX_W-1:0] dst;
   } cmd_t;

endpackage

// File: rtl/reg_seq_cmd_buf.sv
// One-entry pending-command holding register. A push and a pop in the
// same cycle leave the entry full with the new command.
module reg_seq_cmd_buf
   import reg_seq_defs::*;
(
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  cmd_t push_cmd,
   input  logic pop,
   output logic full,
   output cmd_t cmd
);

   logic full_q, full_d;
   cmd_t data_q, data_d;

   // next entry contents: a pop empties the entry, a push refills it
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (pop) full_d = 1'b0;
      if (push) begin
         full_d = 1'b1;
         data_d = push_cmd;
      end
   end

   // entry storage; reset discards any pending command
   always_ff @(posedge clock) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full = full_q;
   assign cmd  = data_q;

endmodule

// File: rtl/reg_bus_sequencer.sv
// Register-file bus strobe sequencer. Defining REG_SEQ_CMD_BUF_EN adds a
// one-entry pending buffer so commands run back-to-back.
module reg_bus_sequencer
   import reg_seq_defs::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int NUM_REGS      = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cmdValid,
   output logic                 cmdReady,
   input  logic [1:0]           cmdOp,
   input  logic [REG_IDX_W-1:0] cmdSrc,
   input  logic [REG_IDX_W-1:0] cmdDst,
   output logic                 done,
   output logic                 busy,
   output logic [NUM_REGS-1:0]  notOE,
   output logic [NUM_REGS-1:0]  notLoad,
   output logic                 pcInc,
   output logic                 pcNotReset
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   // active-low one-hot select; out-of-range indices select nothing
   function automatic logic [NUM_REGS-1:0] sel_n(
      input logic [REG_IDX_W-1:0] idx
   );
      logic [NUM_REGS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_REGS; i++)
         if (int'(idx) == i) v[i] = 1'b0;
      return v;
   endfunction

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   cmd_t                cmd_q, cmd_d;
   logic [NUM_REGS-1:0] not_oe_q, not_oe_d;
   logic [NUM_REGS-1:0] not_load_q, not_load_d;
   logic                pc_inc_q, pc_inc_d;
   logic                pc_not_reset_q, pc_not_reset_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                cmd_ready_q, cmd_ready_d;

   cmd_t in_cmd, start_cmd;
   logic accept, free, start;

   assign in_cmd = cmd_t'{op: op_e'(cmdOp), src: cmdSrc, dst: cmdDst};
   assign accept = cmdValid && cmd_ready_q;

`ifdef REG_SEQ_CMD_BUF_EN
   logic buf_full, buf_push, buf_pop, buf_full_next;
   cmd_t buf_cmd;

   reg_seq_cmd_buf u_cmd_buf (
      .clock    (clock),
      .reset    (reset),
      .push     (buf_push),
      .push_cmd (in_cmd),
      .pop      (buf_pop),
      .full     (buf_full),
      .cmd      (buf_cmd)
   );

   // the final (done) cycle may hand straight over to the next command
   assign free          = (state_q == IDLE) || done_q;
   assign buf_pop       = free && buf_full;
   assign buf_push      = accept && !(free && !buf_full);
   assign buf_full_next = (buf_full && !buf_pop) || buf_push;
`else
   assign free = (state_q == IDLE);
`endif

   // next state, command capture and next registered strobe values
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      start     = 1'b0;
      start_cmd = in_cmd;

      unique case (state_q)
         DRIVE: begin
            if (cnt_q <= 4'd1)
               state_d = (cmd_q.op == OP_MOV) ? LOAD : IDLE;
            else
               cnt_d = cnt_q - 4'd1;
         end
         LOAD, INC, PCRST: state_d = IDLE;
         default: ;
      endcase

`ifdef REG_SEQ_CMD_BUF_EN
      if (free && buf_full) begin
         start     = 1'b1;
         start_cmd = buf_cmd;
      end else if (free && accept) begin
         start = 1'b1;
      end
`else
      start = free && accept;
`endif

      if (start) begin
         cmd_d = start_cmd;
         unique case (start_cmd.op)
            OP_PCINC:   state_d = INC;
            OP_PCRESET: state_d = PCRST;
            default: begin
               state_d = DRIVE;
               cnt_d   = SETTLE_INIT;
            end
         endcase
      end

      not_oe_d       = '1;
      not_load_d     = '1;
      pc_inc_d       = (state_d == INC);
      pc_not_reset_d = (state_d != PCRST);
      busy_d         = (state_d != IDLE);
      done_d         = (state_d == LOAD) || (state_d == INC) ||
                       (state_d == PCRST) ||
                       (state_d == DRIVE && cmd_d.op == OP_OUT &&
                        cnt_d == 4'd1);
      if (state_d == DRIVE || state_d == LOAD) not_oe_d = sel_n(cmd_d.src);
      if (state_d == LOAD) not_load_d = sel_n(cmd_d.dst);

`ifdef REG_SEQ_CMD_BUF_EN
      cmd_ready_d = !buf_full_next;
`else
      cmd_ready_d = (state_d == IDLE);
`endif
   end

   // state and strobe registers; reset aborts any command in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         cmd_q          <= '0;
         not_oe_q       <= '1;
         not_load_q     <= '1;
         pc_inc_q       <= 1'b0;
         pc_not_reset_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
         cmd_ready_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         cmd_q          <= cmd_d;
         not_oe_q       <= not_oe_d;
         not_load_q     <= not_load_d;
         pc_inc_q       <= pc_inc_d;
         pc_not_reset_q <= pc_not_reset_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
         cmd_ready_q    <= cmd_ready_d;
      end
   end

   assign cmdReady   = cmd_ready_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign notOE      = not_oe_q;
   assign notLoad    = not_load_q;
   assign pcInc      = pc_inc_q;
   assign pcNotReset = pc_not_reset_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: two instances (settle 1 and 3) driven by
// directed and random commands, checked against per-command strobe traces.
module tb_reg_bus_sequencer;

   localparam int ND = 2;

   typedef struct {
      logic [7:0] oe;
      logic [7:0] ld;
      logic       inc;
      logic       nrst;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst      [ND];
   logic       cmd_valid[ND];
   logic       cmd_ready[ND];
   logic [1:0] cmd_op   [ND];
   logic [2:0] cmd_src  [ND];
   logic [2:0] cmd_dst  [ND];
   logic       done     [ND];
   logic       busy     [ND];
   logic [7:0] not_oe   [ND];
   logic [7:0] not_load [ND];
   logic       pc_inc   [ND];
   logic       pc_nrst  [ND];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      reg_bus_sequencer #(
         .SETTLE_CYCLES (g == 0 ? 1 : 3),
         .NUM_REGS      (8)
      ) u_dut (
         .clock      (clk),
         .reset      (rst[g]),
         .cmdValid   (cmd_valid[g]),
         .cmdReady   (cmd_ready[g]),
         .cmdOp      (cmd_op[g]),
         .cmdSrc     (cmd_src[g]),
         .cmdDst     (cmd_dst[g]),
         .done       (done[g]),
         .busy       (busy[g]),
         .notOE      (not_oe[g]),
         .notLoad    (not_load[g]),
         .pcInc      (pc_inc[g]),
         .pcNotReset (pc_nrst[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   task automatic check_idle(input int d, input string tag);
      check($sformatf("%s d%0d oe", tag, d), 32'(not_oe[d]), 32'hFF);
      check($sformatf("%s d%0d ld", tag, d), 32'(not_load[d]), 32'hFF);
      check($sformatf("%s d%0d done", tag, d), 32'(done[d]), 0);
      check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 0);
      check($sformatf("%s d%0d rdy", tag, d), 32'(cmd_ready[d]), 1);
      check($sformatf("%s d%0d inc", tag, d), 32'(pc_inc[d]), 0);
      check($sformatf("%s d%0d nrst", tag, d), 32'(pc_nrst[d]), 1);
   endtask

   task automatic check_reset_vals(input int d, input string tag);
      check($sformatf("%s d%0d oe", tag, d), 32'(not_oe[d]), 32'hFF);
      check($sformatf("%s d%0d ld", tag, d), 32'(not_load[d]), 32'hFF);
      check($sformatf("%s d%0d nrst", tag, d), 32'(pc_nrst[d]), 0);
      check($sformatf("%s d%0d inc", tag, d), 32'(pc_inc[d]), 0);
      check($sformatf("%s d%0d done", tag, d), 32'(done[d]), 0);
      check($sformatf("%s d%0d busy", tag, d), 32'(busy[d]), 0);
      check($sformatf("%s d%0d rdy", tag, d), 32'(cmd_ready[d]), 0);
   endtask

   // expected per-cycle strobes of one command, straight from its timing
   task automatic build_trace(input int s, input logic [1:0] op,
                              input logic [2:0] src, input logic [2:0] dst,
                              output exp_t q[$]);
      exp_t e;
      logic [7:0] one;
      q = {};
      one = 8'd1;
      e.oe = 8'hFF; e.ld = 8'hFF; e.inc = 0; e.nrst = 1; e.done = 0;
      case (op)
         2'd1: begin e.inc = 1; e.done = 1; q.push_back(e); end
         2'd2: begin e.nrst = 0; e.done = 1; q.push_back(e); end
         default: begin
            e.oe = ~(one << src);
            for (int i = 0; i < s; i++) begin
               e.done = (op == 2'd3) && (i == s - 1);
               q.push_back(e);
            end
            if (op == 2'd0) begin
               e.ld = ~(one << dst);
               e.done = 1;
               q.push_back(e);
            end
         end
      endcase
   endtask

   task automatic wait_ready(input int d, output bit ok);
      int k = 0;
      while (!cmd_ready[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      ok = cmd_ready[d];
      if (!ok) check($sformatf("ready_timeout d%0d", d), 0, 1);
   endtask

   // issue one command at a negedge and follow its whole strobe trace
   task automatic run_cmd(input int d, input logic [1:0] op,
                          input logic [2:0] src, input logic [2:0] dst);
      exp_t q[$];
      bit ok;
      string t;
      build_trace(settle_of(d), op, src, dst, q);
      wait_ready(d, ok);
      if (!ok) return;
      cmd_valid[d] = 1'b1;
      cmd_op[d]  = op;
      cmd_src[d] = src;
      cmd_dst[d] = dst;
      @(posedge clk);
      #1;
      cmd_valid[d] = 1'b0;
      foreach (q[i]) begin
         @(negedge clk);
         t = $sformatf("op%0d s%0d d%0d c%0d dut%0d", op, src, dst, i, d);
         check({t, " oe"}, 32'(not_oe[d]), 32'(q[i].oe));
         check({t, " ld"}, 32'(not_load[d]), 32'(q[i].ld));
         check({t, " inc"}, 32'(pc_inc[d]), 32'(q[i].inc));
         check({t, " nrst"}, 32'(pc_nrst[d]), 32'(q[i].nrst));
         check({t, " done"}, 32'(done[d]), 32'(q[i].done));
         check({t, " busy"}, 32'(busy[d]), 1);
         check({t, " rdy"}, 32'(cmd_ready[d]), 0);
         if (i < q.size() - 1) begin
            cmd_valid[d] = 1'($urandom_range(0, 1));
            cmd_op[d]  = 2'($urandom);
            cmd_src[d] = 3'($urandom);
            cmd_dst[d] = 3'($urandom);
         end else begin
            cmd_valid[d] = 1'b0;
         end
      end
      @(negedge clk);
      check_idle(d, "after");
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_reset_vals(d, "in_reset");
      end
      rst[d] = 1'b0;
      @(negedge clk);
      check_idle(d, "post_reset");
   endtask

   task automatic reset_mid_cmd(input int d);
      bit ok;
      wait_ready(d, ok);
      if (!ok) return;
      cmd_valid[d] = 1'b1;
      cmd_op[d]  = 2'd0;
      cmd_src[d] = 3'd1;
      cmd_dst[d] = 3'd3;
      @(posedge clk);
      #1;
      cmd_valid[d] = 1'b0;
      @(negedge clk);
      check($sformatf("abort drive d%0d oe", d), 32'(not_oe[d]), 32'hFD);
      rst[d] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_reset_vals(d, "abort");
      end
      rst[d] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check($sformatf("abort ld3 d%0d", d), 32'(not_load[d][3]), 1);
         check($sformatf("abort done d%0d", d), 32'(done[d]), 0);
         check($sformatf("abort oe d%0d", d), 32'(not_oe[d]), 32'hFF);
      end
      check_idle(d, "abort_end");
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1;
         cmd_valid[d] = 1'b0;
         cmd_op[d] = '0;
         cmd_src[d] = '0;
         cmd_dst[d] = '0;
      end
      for (int d = 0; d < ND; d++) do_reset(d);

      run_cmd(0, 2'd0, 3'd2, 3'd5);
      run_cmd(0, 2'd1, 3'd0, 3'd0);
      run_cmd(0, 2'd2, 3'd0, 3'd0);
      run_cmd(0, 2'd3, 3'd6, 3'd0);
      run_cmd(0, 2'd0, 3'd4, 3'd4);
      run_cmd(1, 2'd0, 3'd7, 3'd0);
      run_cmd(1, 2'd3, 3'd4, 3'd0);
      run_cmd(1, 2'd0, 3'd6, 3'd7);

      reset_mid_cmd(1);
      run_cmd(1, 2'd1, 3'd0, 3'd0);
      reset_mid_cmd(0);
      run_cmd(0, 2'd0, 3'd3, 3'd1);

      for (int n = 0; n < 80; n++) begin
         int d;
         int gap;
         d = n % ND;
         run_cmd(d, 2'($urandom), 3'($urandom), 3'($urandom));
         gap = $urandom_range(0, 2);
         for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            check_idle(d, "gap");
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
